fpu_instr_sequencer: RTL

Fetch/decode/issue sequencer for the FPU datapath. Drives the 8-bit address of the 16-bit instruction memory, decodes each word into a 2-bit opcode and a 13-bit data-memory operand address, and issues one operation at a time to the FPU execute stage over a valid/ready handshake. It waits for completion before fetching the next word, and halts after a programmable number of instructions.

---
 rtl/fpu_instr_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/fpu_instr_sequencer.sv
// fpu_instr_sequencer: fetch/decode/issue control for the FPU datapath.
// One operation in flight at a time; halts after PROG_LEN words.
module fpu_instr_sequencer #(
  parameter int PROG_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_instr,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [1:0]  op_code,
  output logic [12:0] op_daddr,
  input  logic        fpu_done,
  output logic        busy,
  output logic        halted,
  output logic [8:0]  retired_cnt,
  output logic [8:0]  illegal_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [7:0] LAST_PC = 8'(PROG_LEN - 1);

  state_t     state;
  logic [7:0] pc;
  logic       last;

  assign last      = (pc == LAST_PC);
  assign imem_addr = pc;
  assign op_valid  = (state == S_ISSUE);
  assign halted    = (state == S_HALT);
  assign busy      = (state == S_FETCH) ||
                     (state == S_ISSUE) ||
                     (state == S_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      op_code     <= '0;
      op_daddr    <= '0;
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc          <= '0;
            retired_cnt <= '0;
            illegal_cnt <= '0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_instr[2]) begin
            // reserved bit set: skip the word in this one cycle
            illegal_cnt <= illegal_cnt + 9'd1;
            if (last) state <= S_HALT;
            else      pc    <= pc + 8'd1;
          end else begin
            op_code  <= imem_instr[1:0];
            op_daddr <= imem_instr[15:3];
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (fpu_done) begin
            retired_cnt <= retired_cnt + 9'd1;
            if (last) begin
              state <= S_HALT;
            end else begin
              pc    <= pc + 8'd1;
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
